cacheline_adapter: RTL
======================

Name: cacheline_adapter

Overview:
- Memory-side responder for the data cache's DFP interface.
- Accepts a full-line read (fetch) or write (writeback) request, held as a level from the cache controller, and converts it into a 4-beat 64-bit burst on the banked-memory interface.
- Answers with a single-cycle dfp_resp; on reads, the assembled 256-bit line is presented on dfp_rdata.
- Sits between dcache_control/datapath and the burst memory model or arbiter.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, memory data bus width; BEATS = LINE_WIDTH/BEAT_WIDTH (4).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dfp_addr  input  ADDR_WIDTH  line address from cache; low log2(LINE_WIDTH/8) bits ignored.
- dfp_read  input  1  fetch request, level, held until dfp_resp.
- dfp_write  input  1  writeback request, level, held until dfp_resp.
- dfp_wdata  input  LINE_WIDTH  writeback line, stable while dfp_write high.
- dfp_rdata  output  LINE_WIDTH  fetched line.
- dfp_resp  output  1  one-cycle completion pulse.
- bmem_addr  output  ADDR_WIDTH  burst base address, line-aligned.
- bmem_read  output  1  read burst command, one cycle.
- bmem_write  output  1  write beat valid.
- bmem_wdata  output  BEAT_WIDTH  write beat data.
- bmem_ready  input  1  memory accepts command/beat this cycle.
- bmem_raddr  input  ADDR_WIDTH  base address of returning read data.
- bmem_rdata  input  BEAT_WIDTH  read beat.
- bmem_rvalid  input  1  read beat valid.

Behaviour:
- Reset (async, rst_n=0): state IDLE, beat counter 0, dfp_resp=0, dfp_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0.
- FSM states: IDLE, WR_BURST, RD_CMD, RD_BURST, DONE.
- IDLE:
  - dfp_write=1: capture dfp_wdata and aligned address; go to WR_BURST.
  - Else dfp_read=1: capture aligned address; go to RD_CMD.
  - Both high: write wins; the read is served after the write completes if still asserted.
- WR_BURST:
  - bmem_write=1, bmem_addr=base, bmem_wdata=beat[cnt], where beat 0 = bits [63:0].
  - cnt advances only on cycles with bmem_ready=1.
  - After beat BEATS-1 is accepted, go to DONE.
- RD_CMD:
  - bmem_read=1 and bmem_addr=base, held until bmem_ready=1 (one accepted cycle); then go to RD_BURST.
- RD_BURST:
  - Each bmem_rvalid=1 stores bmem_rdata into slot cnt; beats arrive in order, lowest first.
  - After the 4th beat, go to DONE.
  - Gaps in rvalid are legal.
- DONE:
  - dfp_resp=1 for exactly this cycle; next state IDLE.
  - dfp_rdata holds the assembled line from DONE until the next read's DONE; writes do not alter it.
- Latency: minimum write = 1 + 4 + 1 = 6 cycles from request to resp; minimum read = 1 + 1 + 4 + 1 cycles after request, plus memory latency.
- Back-to-back requests: the cache drops the request the cycle after resp. A new request seen in IDLE the cycle after DONE (writeback then fetch) is accepted immediately, with no bubble beyond IDLE.
- dfp_read/dfp_write are not re-sampled mid-burst; deassertion mid-burst is a protocol violation and the burst still completes.
- bmem_rvalid outside RD_BURST is ignored.
- Reset mid-burst aborts immediately with no resp.

Optional Feature:
- Macro: CACHELINE_ADAPTER_RADDR_CHECK_EN.
- With the macro: a beat whose bmem_raddr != captured base is discarded (cnt does not advance), and sticky output raddr_err (1 bit, reset 0, cleared only by reset) is set.
- Without the macro: bmem_raddr is unused, every rvalid beat is accepted, and the raddr_err port is absent.

Decomposition:
- cache_types package gains: adapter_state_t enum (IDLE, WR_BURST, RD_CMD, RD_BURST, DONE), BEATS, and LINE_OFFSET_BITS.
- One natural sub-module, cacheline_beat_buf: LINE_WIDTH register with a beat-indexed write port (read assembly) and a beat-indexed read mux (write disassembly).

Test Plan:
- Write, bmem_ready always 1: dfp_write, addr 0x1000_0024, wdata {D3,D2,D1,D0} -> bmem_addr 0x1000_0020; bmem_wdata D0..D3 on 4 consecutive cycles; dfp_resp one cycle later; total 6 cycles.
- Read with rvalid gaps: dfp_read, addr 0x0000_0040; beats 0x11,0x22,0x33,0x44 with 2-cycle gaps -> single bmem_read; dfp_rdata = {0x44,0x33,0x22,0x11}; dfp_resp exactly one cycle.
- Writeback then fetch: dfp_write, then dfp_read the cycle after resp -> read accepted in that IDLE cycle; two resp pulses; no stray bmem_read during the write.
- bmem_ready stall: ready low for 3 cycles on beat 2 -> bmem_wdata holds beat 2 and cnt frozen; exactly 4 beats accepted.
- Async reset during RD_BURST after 2 beats -> outputs zero immediately; no dfp_resp; next read completes normally.
- With CACHELINE_ADAPTER_RADDR_CHECK_EN: one beat with raddr 0x80 while base is 0x40 -> beat dropped; raddr_err=1; line completes from the 4 correctly addressed beats.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types and line-geometry constants for the data-cache memory-side adapter.
package cache_types;

  localparam int BEATS            = 4;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    RD_CMD,
    RD_BURST,
    DONE
  } adapter_state_t;

endpackage

// File: rtl/cacheline_beat_buf.sv
// Line-wide register written either whole (writeback capture) or one beat at a time
// (fetch assembly), with a beat-indexed read mux feeding the write burst.
module cacheline_beat_buf
  import cache_types::*;
#(
  parameter int BEAT_WIDTH = 64,
  parameter int NBEATS     = BEATS,
  parameter int IDX_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_en_i,
  input  logic [NBEATS*BEAT_WIDTH-1:0] load_line_i,
  input  logic                         beat_we_i,
  input  logic [IDX_W-1:0]             beat_wr_idx_i,
  input  logic [BEAT_WIDTH-1:0]        beat_wdata_i,
  input  logic [IDX_W-1:0]             beat_rd_idx_i,
  output logic [BEAT_WIDTH-1:0]        beat_rdata_o,
  output logic [NBEATS*BEAT_WIDTH-1:0] line_o
);

  logic [NBEATS-1:0][BEAT_WIDTH-1:0] buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (load_en_i) begin
      buf_q <= load_line_i;
    end else if (beat_we_i) begin
      buf_q[beat_wr_idx_i] <= beat_wdata_i;
    end
  end

  assign beat_rdata_o = buf_q[beat_rd_idx_i];
  assign line_o       = buf_q;

endmodule

// File: rtl/cacheline_adapter.sv
// Converts level-held full-line fetch/writeback requests into 4-beat bursts on the banked memory.
// Optional macro CACHELINE_ADAPTER_RADDR_CHECK_EN: drop read beats whose bmem_raddr mismatches, flag raddr_err.
module cacheline_adapter
  import cache_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  output logic                  raddr_err,
`endif
  input  logic                  bmem_rvalid
);

  localparam int NB    = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};

  adapter_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    load_en;
  logic                    beat_we;
  logic                    beat_ok;
  logic [LINE_WIDTH-1:0]   buf_line;
  logic [BEAT_WIDTH-1:0]   buf_beat;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  logic err_q;

  assign beat_ok = bmem_rvalid && (bmem_raddr == base_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == RD_BURST && bmem_rvalid && (bmem_raddr != base_q)) begin
      err_q <= 1'b1;
    end
  end

  assign raddr_err = err_q;
`else
  logic unused_raddr;

  assign beat_ok      = bmem_rvalid;
  assign unused_raddr = ^bmem_raddr;
`endif

  cacheline_beat_buf #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .NBEATS     (NB),
    .IDX_W      (CNT_W)
  ) u_beat_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_en_i     (load_en),
    .load_line_i   (dfp_wdata),
    .beat_we_i     (beat_we),
    .beat_wr_idx_i (cnt_q),
    .beat_wdata_i  (bmem_rdata),
    .beat_rd_idx_i (cnt_q),
    .beat_rdata_o  (buf_beat),
    .line_o        (buf_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    rdata_d = rdata_q;
    load_en = 1'b0;
    beat_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Write has priority; a concurrent read stays asserted and is taken afterwards.
        if (dfp_write) begin
          base_d  = dfp_addr & ADDR_MASK;
          load_en = 1'b1;
          state_d = WR_BURST;
        end else if (dfp_read) begin
          base_d  = dfp_addr & ADDR_MASK;
          state_d = RD_CMD;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (beat_ok) begin
          beat_we = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            // The final beat bypasses the buffer so dfp_rdata is valid in DONE.
            rdata_d = buf_line;
            rdata_d[(NB-1)*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dfp_resp   = (state_q == DONE);
  assign dfp_rdata  = rdata_q;
  assign bmem_read  = (state_q == RD_CMD);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_addr  = base_q;
  assign bmem_wdata = buf_beat;

endmodule
